// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the instruction-fetch PC generator.
package fetch_pc_gen_pkg;

   localparam int unsigned      ADDR_WIDTH_DEFAULT = 32;
   localparam logic [31:0]      RESET_PC_DEFAULT   = 32'hBFC0_0000;
   localparam int unsigned      PC_INC             = 4;

   // 2'd3 is not a legal state; the FSM steers it back to ST_RUN.
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen_pending.sv
// Branch target captured while the pipeline is stalled, replayed once the stall drops.
module pending_branch_reg #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   output logic                  q_valid,
   output logic [ADDR_WIDTH-1:0] q_addr
);

   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = d_addr;
      end else if (clear) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign q_valid = valid_q;
   assign q_addr  = addr_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds the fetch PC, drives the instruction ROM and applies
// flush / branch / stalled-branch redirects in priority order.
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] exc_pc,
   input  logic                  branch_flag,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  addr_err
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  addr_err_q, addr_err_d;
   logic                  rom_en_q, rom_en_d;
   logic                  pc_load;
   logic                  pend_load, pend_clear;
   logic                  pending_valid;
   logic [ADDR_WIDTH-1:0] pending_addr;

   pending_branch_reg #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pend (
      .clk     (clk),
      .rst     (rst),
      .load    (pend_load),
      .clear   (pend_clear),
      .d_addr  (branch_addr),
      .q_valid (pending_valid),
      .q_addr  (pending_addr)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_load    = 1'b0;
      pend_load  = 1'b0;
      pend_clear = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            if (flush) begin
               pc_d       = exc_pc;
               pc_load    = 1'b1;
               pend_clear = 1'b1;
            end
         end
         ST_RUN, ST_HOLD: begin
            if (flush) begin
               pc_d       = exc_pc;
               pc_load    = 1'b1;
               pend_clear = 1'b1;
               state_d    = ST_RUN;
            end else if (stall) begin
               // PC holds; a branch resolved under stall is parked, latest one wins.
               if (branch_flag) begin
                  pend_load = 1'b1;
                  state_d   = ST_HOLD;
               end
            end else if (branch_flag) begin
               pc_d       = branch_addr;
               pc_load    = 1'b1;
               pend_clear = 1'b1;
               state_d    = ST_RUN;
            end else if (pending_valid) begin
               pc_d       = pending_addr;
               pc_load    = 1'b1;
               pend_clear = 1'b1;
               state_d    = ST_RUN;
            end else begin
               pc_d    = pc_q + ADDR_WIDTH'(PC_INC);
               pc_load = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
      addr_err_d = pc_load ? (pc_d[1:0] != 2'b00) : addr_err_q;
      rom_en_d   = (state_d == ST_RUN) || (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         addr_err_q <= 1'b0;
         rom_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_err_q <= addr_err_d;
         rom_en_q   <= rom_en_d;
      end
   end

   assign pc       = pc_q;
   assign rom_addr = pc_q;
   assign rom_en   = rom_en_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed vectors, a behavioural fetch model
// compared every negedge, and literal expectations along the directed sequence.
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, branch_flag;
   logic [31:0] exc_pc, branch_addr;
   logic        rom_en, addr_err;
   logic [31:0] rom_addr, pc;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic        checking = 1'b0;
   logic        seen_400 = 1'b0;

   // Behavioural model state
   logic [31:0] m_pc;
   logic        m_en, m_err, m_pv, m_boot;
   logic [31:0] m_pa;

   fetch_pc_gen #(
      .ADDR_WIDTH (32),
      .RESET_PC   (32'hBFC0_0000)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .exc_pc      (exc_pc),
      .branch_flag (branch_flag),
      .branch_addr (branch_addr),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .pc          (pc),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Fetch rules: boot cycle, then flush > stall(park branch) > branch > pending > pc+4.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc   <= 32'hBFC0_0000;
         m_en   <= 1'b0;
         m_err  <= 1'b0;
         m_pv   <= 1'b0;
         m_pa   <= 32'h0;
         m_boot <= 1'b1;
      end else if (m_boot) begin
         m_boot <= 1'b0;
         m_en   <= 1'b1;
         if (flush) begin
            m_pc  <= exc_pc;
            m_err <= (exc_pc[1:0] != 2'b00);
         end
      end else if (flush) begin
         m_pc  <= exc_pc;
         m_err <= (exc_pc[1:0] != 2'b00);
         m_pv  <= 1'b0;
      end else if (stall) begin
         if (branch_flag) begin
            m_pa <= branch_addr;
            m_pv <= 1'b1;
         end
      end else if (branch_flag) begin
         m_pc  <= branch_addr;
         m_err <= (branch_addr[1:0] != 2'b00);
         m_pv  <= 1'b0;
      end else if (m_pv) begin
         m_pc  <= m_pa;
         m_err <= (m_pa[1:0] != 2'b00);
         m_pv  <= 1'b0;
      end else begin
         m_pc  <= m_pc + 32'd4;
         m_err <= ((m_pc[1:0] + 2'd0) != 2'b00);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("model_pc",       pc,                         m_pc);
         check("model_rom_addr", rom_addr,                   m_pc);
         check("model_rom_en",   {31'b0, rom_en},            {31'b0, m_en});
         check("model_addr_err", {31'b0, addr_err},          {31'b0, m_err});
         check("model_pending",  {31'b0, u_dut.pending_valid}, {31'b0, m_pv});
         if (pc == 32'hBFC0_0400) seen_400 = 1'b1;
      end
   end

   task automatic cyc(input logic st, input logic fl, input logic bf,
                      input logic [31:0] ba, input logic [31:0] ep);
      stall       = st;
      flush       = fl;
      branch_flag = bf;
      branch_addr = ba;
      exc_pc      = ep;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic exp_out(input string name, input logic [31:0] e_pc,
                          input logic e_en, input logic e_err);
      check({name, "_pc"},  pc,                e_pc);
      check({name, "_en"},  {31'b0, rom_en},   {31'b0, e_en});
      check({name, "_err"}, {31'b0, addr_err}, {31'b0, e_err});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
      branch_addr = '0; exc_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      checking = 1'b1;
      rst = 1'b0;

      // Reset release and boot cycle
      exp_out("boot0", 32'hBFC0_0000, 1'b0, 1'b0);
      idle(); exp_out("boot1", 32'hBFC0_0000, 1'b1, 1'b0);
      idle(); exp_out("seq1",  32'hBFC0_0004, 1'b1, 1'b0);
      idle(); exp_out("seq2",  32'hBFC0_0008, 1'b1, 1'b0);

      // Plain branch
      cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 32'h0); exp_out("br",   32'hBFC0_0100, 1'b1, 1'b0);
      idle();                                      exp_out("br+4", 32'hBFC0_0104, 1'b1, 1'b0);

      // Branch under 3-cycle stall
      cyc(1'b1, 1'b0, 1'b1, 32'hBFC0_0200, 32'h0); exp_out("stl1", 32'hBFC0_0104, 1'b1, 1'b0);
      check("stl1_pend", {31'b0, u_dut.pending_valid}, 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);         exp_out("stl2", 32'hBFC0_0104, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);         exp_out("stl3", 32'hBFC0_0104, 1'b1, 1'b0);
      idle();                                      exp_out("pend", 32'hBFC0_0200, 1'b1, 1'b0);
      check("pend_clr", {31'b0, u_dut.pending_valid}, 32'd0);
      idle();                                      exp_out("pend+4", 32'hBFC0_0204, 1'b1, 1'b0);

      // Repeated stalled branch overwrites the parked target
      cyc(1'b1, 1'b0, 1'b1, 32'hBFC0_0300, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 32'hBFC0_0340, 32'h0); exp_out("ovw_hold", 32'hBFC0_0204, 1'b1, 1'b0);
      idle();                                      exp_out("ovw",      32'hBFC0_0340, 1'b1, 1'b0);
      idle();                                      exp_out("ovw+4",    32'hBFC0_0344, 1'b1, 1'b0);

      // Fresh branch beats a parked one
      cyc(1'b1, 1'b0, 1'b1, 32'hBFC0_0500, 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0600, 32'h0); exp_out("fresh",   32'hBFC0_0600, 1'b1, 1'b0);
      idle();                                      exp_out("fresh+4", 32'hBFC0_0604, 1'b1, 1'b0);

      // Flush overrides stall and branch, drops pending
      cyc(1'b1, 1'b1, 1'b1, 32'hBFC0_0700, 32'hBFC0_0380); exp_out("flush", 32'hBFC0_0380, 1'b1, 1'b0);
      check("flush_pend", {31'b0, u_dut.pending_valid}, 32'd0);
      idle(); exp_out("flush+4", 32'hBFC0_0384, 1'b1, 1'b0);
      idle(); exp_out("flush+8", 32'hBFC0_0388, 1'b1, 1'b0);

      // Wrap-around
      cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0); exp_out("top",  32'hFFFF_FFFC, 1'b1, 1'b0);
      idle();                                      exp_out("wrap", 32'h0000_0000, 1'b1, 1'b0);
      idle();                                      exp_out("wrap4", 32'h0000_0004, 1'b1, 1'b0);

      // Misaligned targets
      cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0102, 32'h0); exp_out("mis",      32'hBFC0_0102, 1'b1, 1'b1);
      idle();                                      exp_out("mis+4",    32'hBFC0_0106, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);         exp_out("mis_stl",  32'hBFC0_0106, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0200, 32'h0); exp_out("realign",  32'hBFC0_0200, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'hBFC0_0383); exp_out("mis_exc",  32'hBFC0_0383, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0208, 32'h0); exp_out("realign2", 32'hBFC0_0208, 1'b1, 1'b0);

      // Asynchronous reset while holding a parked target
      cyc(1'b1, 1'b0, 1'b1, 32'hBFC0_0400, 32'h0);
      check("hold_pend", {31'b0, u_dut.pending_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      exp_out("arst", 32'hBFC0_0000, 1'b0, 1'b0);
      check("arst_pend", {31'b0, u_dut.pending_valid}, 32'd0);
      stall = 1'b0; branch_flag = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Boot cycle ignores branch and stall
      cyc(1'b0, 1'b0, 1'b1, 32'hBFC0_0600, 32'h0); exp_out("reboot", 32'hBFC0_0000, 1'b1, 1'b0);
      idle(); exp_out("reseq1", 32'hBFC0_0004, 1'b1, 1'b0);
      idle(); exp_out("reseq2", 32'hBFC0_0008, 1'b1, 1'b0);
      idle(); exp_out("reseq3", 32'hBFC0_000C, 1'b1, 1'b0);

      @(negedge clk);
      #1;
      check("no_stale_400", {31'b0, seen_400}, 32'd0);
      checking = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
